// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tristate net with break-before-make dead time and hold pre-emption.
// One-cycle registered grant/release latency; a holder is pre-empted only while another source waits.
module tristate_bus_arbiter #(
   parameter int SOURCE_COUNT = 4,
   parameter int DEAD_CYCLES  = 1,
   parameter int MAX_HOLD     = 8
) (
   input  logic                            i_clk,
   input  logic                            i_nrst,
   input  logic [SOURCE_COUNT-1:0]         i_req,
   output logic [SOURCE_COUNT-1:0]         o_noe,
   output logic                            o_gnt_valid,
   output logic [$clog2(SOURCE_COUNT)-1:0] o_gnt_id,
   input  logic                            i_net_noe,
   output logic                            o_fault,
   output logic [7:0]                      o_fault_cnt
);

   localparam int IDW = $clog2(SOURCE_COUNT);
   localparam int HW  = $clog2(MAX_HOLD + 1);
   localparam int DW  = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_DEAD  = 2'd2
   } state_t;

   state_t                  state_q;
   logic [SOURCE_COUNT-1:0] noe_q;
   logic                    gnt_vld_q;
   logic [IDW-1:0]          gnt_id_q;
   logic [IDW-1:0]          ptr_q;
   logic [HW-1:0]           hold_q;
   logic [DW-1:0]           dead_q;
   logic                    fault_q;
   logic [7:0]              fault_cnt_q;

   logic                    win_vld_d;
   logic [IDW-1:0]          win_id_d;
   logic [SOURCE_COUNT-1:0] win_onehot_d;
   logic [IDW-1:0]          ptr_d;
   logic [SOURCE_COUNT-1:0] own_mask_d;
   logic                    other_req_d;
   logic                    dead_last_d;
   logic                    do_grant_d;
   logic                    release_d;
   logic                    net_exp_d;
   logic                    mismatch_d;
   int unsigned             idx;

   // Walk from the farthest candidate back to ptr so the first set bit at/after ptr wins.
   always_comb begin
      win_vld_d    = 1'b0;
      win_id_d     = '0;
      idx          = 0;
      for (int k = SOURCE_COUNT - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= SOURCE_COUNT) idx = idx - SOURCE_COUNT;
         if (i_req[idx]) begin
            win_vld_d = 1'b1;
            win_id_d  = IDW'(idx);
         end
      end
      win_onehot_d = '0;
      win_onehot_d[win_id_d] = 1'b1;
      if (int'(win_id_d) == SOURCE_COUNT - 1) ptr_d = '0;
      else                                    ptr_d = win_id_d + 1'b1;
   end

   always_comb begin
      own_mask_d = '0;
      own_mask_d[gnt_id_q] = 1'b1;
      other_req_d = |(i_req & ~own_mask_d);
      dead_last_d = (int'(dead_q) == DEAD_CYCLES - 1);
      do_grant_d  = win_vld_d && ((state_q == S_IDLE) || ((state_q == S_DEAD) && dead_last_d));
      release_d   = (state_q == S_DRIVE) &&
                    (!i_req[gnt_id_q] || ((int'(hold_q) == MAX_HOLD - 1) && other_req_d));
      net_exp_d   = (state_q != S_DRIVE);
      mismatch_d  = (i_net_noe !== net_exp_d);
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q     <= S_IDLE;
         noe_q       <= '1;
         gnt_vld_q   <= 1'b0;
         gnt_id_q    <= '0;
         ptr_q       <= '0;
         hold_q      <= '0;
         dead_q      <= '0;
         fault_q     <= 1'b0;
         fault_cnt_q <= '0;
      end else begin
         if (mismatch_d) begin
            fault_q <= 1'b1;
            if (fault_cnt_q != 8'hFF) fault_cnt_q <= fault_cnt_q + 8'd1;
         end

         if (do_grant_d) begin
            state_q   <= S_DRIVE;
            noe_q     <= ~win_onehot_d;
            gnt_vld_q <= 1'b1;
            gnt_id_q  <= win_id_d;
            ptr_q     <= ptr_d;
            hold_q    <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  state_q <= S_IDLE;
               end
               S_DRIVE: begin
                  if (int'(hold_q) != MAX_HOLD) hold_q <= hold_q + 1'b1;
                  if (release_d) begin
                     state_q   <= S_DEAD;
                     noe_q     <= '1;
                     gnt_vld_q <= 1'b0;
                     dead_q    <= '0;
                  end
               end
               S_DEAD: begin
                  if (dead_last_d) state_q <= S_IDLE;
                  else             dead_q  <= dead_q + 1'b1;
               end
               default: begin
                  state_q   <= S_IDLE;
                  noe_q     <= '1;
                  gnt_vld_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_noe       = noe_q;
   assign o_gnt_valid = gnt_vld_q;
   assign o_gnt_id    = gnt_id_q;
   assign o_fault     = fault_q;
   assign o_fault_cnt = fault_cnt_q;

endmodule
